// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: operation encodings and controller states.
package alu_seq_pkg;

    // Operation select as presented on op_i
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/alu_seq_bcd.sv
// Combinational binary-to-BCD converter (double-dabble).
// Least-significant decimal digit lands in bcd_o[3:0].
module alu_seq_bcd #(
    parameter int unsigned IN_W   = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic [IN_W-1:0]     bin_i,
    output logic [4*DIGITS-1:0] bcd_o
);

    logic [4*DIGITS-1:0] bcd;

    // Shift binary in MSB-first, adding 3 to any digit >= 5 before each shift
    always_comb begin
        bcd = '0;
        for (int i = int'(IN_W) - 1; i >= 0; i--) begin
            for (int d = 0; d < int'(DIGITS); d++) begin
                if (bcd[4*d +: 4] >= 4'd5) begin
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
                end
            end
            bcd = {bcd[4*DIGITS-2:0], bin_i[i]};
        end
    end

    assign bcd_o = bcd;

endmodule

// File: rtl/alu_seq_nb.sv
// Sequential ALU: ADD/SUB in one step, shift-add MUL and restoring DIV over WIDTH steps,
// with a start/busy/done handshake.
// Optional BCD output of the registered result is built when ALU_BCD_EN is defined;
// otherwise bcd_out_o is tied to zero.
module alu_seq_nb
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned BCD_DIGITS = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [1:0]              op_i,
    input  logic [WIDTH-1:0]        x_i,
    input  logic [WIDTH-1:0]        y_i,
    input  logic                    cin_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [2*WIDTH-1:0]      result_o,
    output logic                    carry_o,
    output logic                    div_zero_o,
    output logic [4*BCD_DIGITS-1:0] bcd_out_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e               state_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 carry_q;
    logic                 div_zero_q;

    // Working registers; acc_q holds {remainder, quotient} during DIV
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;   // multiplier for MUL, divisor for DIV
    logic [CntW-1:0]      cnt_q;
    logic                 carry_pend_q;

    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       sub_diff;
    logic [2*WIDTH-1:0]   mul_acc_nxt;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH+1:0]     div_trial;
    logic                 div_neg;
    logic [2*WIDTH-1:0]   div_acc_nxt;

    // Single-step arithmetic and one iteration of the MUL and DIV datapaths
    always_comb begin
        add_sum     = {1'b0, x_i} + {1'b0, y_i} + {{WIDTH{1'b0}}, cin_i};
        sub_diff    = {1'b0, x_i} - {1'b0, y_i} - {{WIDTH{1'b0}}, cin_i};
        mul_acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        // Bring in the next dividend bit, then trial-subtract; the extra top bit is the borrow
        div_shift   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial   = {1'b0, div_shift} - {2'b00, mplier_q};
        div_neg     = div_trial[WIDTH+1];
        div_acc_nxt = {(div_neg ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], ~div_neg};
    end

    // Controller FSM with registered handshake and result outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            carry_q      <= 1'b0;
            div_zero_q   <= 1'b0;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            cnt_q        <= '0;
            carry_pend_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        busy_q       <= 1'b1;
                        div_zero_q   <= 1'b0;
                        carry_pend_q <= 1'b0;
                        case (op_e'(op_i))
                            OP_ADD: begin
                                acc_q        <= {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
                                carry_pend_q <= add_sum[WIDTH];
                                state_q      <= DONE;
                            end
                            OP_SUB: begin
                                acc_q        <= {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
                                carry_pend_q <= sub_diff[WIDTH];
                                state_q      <= DONE;
                            end
                            OP_MUL: begin
                                acc_q    <= '0;
                                mcand_q  <= {{WIDTH{1'b0}}, x_i};
                                mplier_q <= y_i;
                                cnt_q    <= CntW'(WIDTH);
                                state_q  <= MUL;
                            end
                            OP_DIV: begin
                                if (y_i == '0) begin
                                    // Divide by zero: quotient 0, remainder is the dividend
                                    acc_q      <= {x_i, {WIDTH{1'b0}}};
                                    div_zero_q <= 1'b1;
                                    state_q    <= DONE;
                                end else begin
                                    acc_q    <= {{WIDTH{1'b0}}, x_i};
                                    mplier_q <= y_i;
                                    cnt_q    <= CntW'(WIDTH);
                                    state_q  <= DIV;
                                end
                            end
                            default: state_q <= IDLE;
                        endcase
                    end
                end
                MUL: begin
                    acc_q    <= mul_acc_nxt;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q <= DONE;
                    end
                end
                DIV: begin
                    acc_q <= div_acc_nxt;
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    result_q <= acc_q;
                    carry_q  <= carry_pend_q;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign carry_o    = carry_q;
    assign div_zero_o = div_zero_q;

`ifdef ALU_BCD_EN
    alu_seq_bcd #(
        .IN_W   (2 * WIDTH),
        .DIGITS (BCD_DIGITS)
    ) u_bcd (
        .bin_i (result_q),
        .bcd_o (bcd_out_o)
    );
`else
    assign bcd_out_o = '0;
`endif

endmodule

// File: doc/alu_seq_nb.md
Name: alu_seq_nb

Overview:
- Parametrised, clocked successor to the team's 4-bit combinational ALU.
- Performs ADD, SUB, MUL and DIV on WIDTH-bit unsigned operands with a start/done handshake.
- MUL is iterative shift-add; DIV is iterative restoring division.
- Sits between the board switch/button front end and the seven-segment display driver.

Parameters:
- WIDTH, 4, operand width in bits (2..16).
- BCD_DIGITS, 5, number of BCD digits on bcd_out. Used only with ALU_BCD_EN; must cover 2^(2*WIDTH)-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B
- cin  in  1  carry-in for ADD, borrow-in for SUB; ignored for MUL/DIV
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when result is valid
- result  out  2*WIDTH  ADD/SUB: {0, sum/diff}; MUL: product; DIV: {remainder, quotient}
- carry  out  1  ADD carry-out, SUB borrow-out, 0 for MUL/DIV
- div_zero  out  1  set on DIV with y==0, cleared at next accepted start
- bcd_out  out  4*BCD_DIGITS  only with ALU_BCD_EN

Behaviour:
- Reset (async assert, clk-synchronous release): state IDLE; busy, done, result, carry, div_zero all 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - On start=1, latch x, y, cin and op; busy goes high next edge.
  - ADD/SUB, and DIV with y==0, go to DONE.
  - MUL goes to MUL with count=WIDTH; DIV goes to DIV with count=WIDTH.
- ADD: {carry, result[W-1:0]} = x + y + cin. SUB: result[W-1:0] = x - y - cin modulo 2^W, carry = 1 when x < y + cin. Upper result bits are 0.
- MUL:
  - Each cycle: if multiplier LSB is 1, add the multiplicand shifted into a 2W-bit accumulator; then shift the multiplier right.
  - Exactly WIDTH iterations, then DONE. Product is exact; no overflow possible.
- DIV:
  - Restoring, MSB-first, one quotient bit per cycle over WIDTH iterations.
  - Trial subtract is W+1 bits wide; restore when the result is negative.
- DIV, y==0: quotient = 0, remainder = x, div_zero = 1, carry = 0. Completes at the ADD/SUB latency.
- DONE: done=1 for exactly one cycle, busy drops in the same cycle, return to IDLE. A start arriving in DONE is ignored.
- Latency from the start-accept edge to the done cycle: ADD/SUB/DIV-by-zero 1 cycle; MUL and DIV WIDTH+1 cycles.
- result, carry and div_zero hold their values until the next accepted start. They do not change while busy, except that the internal accumulator is separate from result.
- start while busy: ignored, with no queuing.
- Operand changes while busy: no effect, because operands are latched.
- rst mid-operation: immediate return to IDLE with all outputs zero; no done pulse.

Optional Feature:
- Macro ALU_BCD_EN.
- Defined:
  - Instantiates a binary-to-BCD converter (double-dabble, combinational) on the registered result.
  - bcd_out has valid digits from the done cycle until the next start; the least-significant digit is in bits [3:0].
- Undefined:
  - Port bcd_out exists but is tied to 0, and no converter logic is built.
  - All other behaviour is identical.

Decomposition:
- Package alu_seq_pkg:
  - op encodings OP_ADD, OP_SUB, OP_MUL, OP_DIV.
  - state enum IDLE/MUL/DIV/DONE.
- Sub-module alu_seq_bcd:
  - parameters IN_W and DIGITS.
  - Instantiated only under ALU_BCD_EN.
- The display layer keeps using the existing seven_seg decoder on bcd_out nibbles.

Test Plan (WIDTH=4):
- ADD x=9, y=8, cin=1 -> one cycle later done=1, result=8'h02, carry=1.
- SUB x=3, y=5, cin=0 -> result=8'h0E, carry=1. Then SUB x=7, y=2, cin=1 -> result=8'h04, carry=0.
- MUL x=15, y=15 -> busy for 5 cycles, done on the 5th edge after start, result=8'hE1. With ALU_BCD_EN, bcd_out=20'h00225.
- DIV x=13, y=4 -> result=8'h13 (remainder 1, quotient 3), div_zero=0, 5-cycle latency. DIV x=7, y=0 -> result=8'h70, div_zero=1, 1-cycle latency.
- Start a MUL, pulse start again with op=ADD at cycle 2 -> ignored, MUL result unaffected. Start a MUL and assert rst at cycle 3 -> busy=0, result=0, no done pulse; the next ADD runs normally.
